// File: rtl/uart_config_controller.sv
// UART runtime configuration sequencer: forwards RX bytes, detects a SYN run,
// runs the ACK/packet/echo handshake and applies the new uart_config_s on END.
module uart_config_controller #(
  parameter int unsigned SYN_NUMBER     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic [7:0] tx_data_o,
  output logic       tx_req_o,
  input  logic       tx_ack_i,
  output logic [5:0] config_o,
  output logic       config_active_o,
  output logic       int_config_req_o,
  output logic       int_config_done_o,
  output logic       int_config_fail_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYN = 8'h16;
  localparam logic [5:0] STD_CONFIGURATION = 6'b11_00_00;
  localparam logic [1:0] END_CONFIGURATION_ID = 2'b00;
  localparam logic [1:0] DATA_WIDTH_ID = 2'b01;
  localparam logic [1:0] PARITY_MODE_ID = 2'b10;
  localparam logic [1:0] STOP_BITS_ID = 2'b11;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] SYN_LAST = 3'(SYN_NUMBER - 1);

  typedef struct packed {
    logic [1:0] data_width;
    logic [1:0] parity_mode;
    logic [1:0] stop_bits;
  } uart_config_s;

  typedef enum logic [1:0] {
    MAIN     = 2'd0,
    CFG_ACK  = 2'd1,
    CFG_IDLE = 2'd2,
    CFG_ECHO = 2'd3
  } state_e;

  // Stop-bit codes 10/11 are reserved.
  function automatic logic stop_bits_legal(input logic [1:0] opt);
    return (opt[1] == 1'b0);
  endfunction

  state_e        state_q;
  logic [2:0]    syn_cnt_q;
  logic [TW-1:0] timer_q;
  uart_config_s  config_q;
  uart_config_s  pending_q;
  logic          end_pending_q;
  logic          active_q;
  logic [7:0]    data_q;
  logic          data_valid_q;
  logic [7:0]    tx_data_q;
  logic          tx_req_q;
  logic          req_q;
  logic          done_q;
  logic          fail_q;

  logic [1:0] rx_id;
  logic [1:0] rx_opt;
  assign rx_id  = rx_data_i[1:0];
  assign rx_opt = rx_data_i[3:2];

  // Protocol FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= MAIN;
      syn_cnt_q     <= 3'd0;
      timer_q       <= '0;
      config_q      <= STD_CONFIGURATION;
      pending_q     <= STD_CONFIGURATION;
      end_pending_q <= 1'b0;
      active_q      <= 1'b0;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_req_q      <= 1'b0;
      req_q         <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      case (state_q)
        MAIN: begin
          if (rx_valid_i) begin
            data_q       <= rx_data_i;
            data_valid_q <= 1'b1;
            if (rx_data_i == SYN) begin
              if (syn_cnt_q == SYN_LAST) begin
                syn_cnt_q <= 3'd0;
                pending_q <= config_q;
                req_q     <= 1'b1;
                tx_data_q <= SYN;
                tx_req_q  <= 1'b1;
                active_q  <= 1'b1;
                state_q   <= CFG_ACK;
              end else begin
                syn_cnt_q <= syn_cnt_q + 3'd1;
              end
            end else begin
              syn_cnt_q <= 3'd0;
            end
          end
        end
        CFG_ACK: begin
          if (rx_valid_i) begin
            fail_q <= 1'b1;
          end
          if (tx_ack_i) begin
            tx_req_q <= 1'b0;
            state_q  <= CFG_IDLE;
          end
        end
        CFG_IDLE: begin
          if (rx_valid_i) begin
            timer_q       <= '0;
            tx_data_q     <= rx_data_i;
            end_pending_q <= (rx_id == END_CONFIGURATION_ID);
            case (rx_id)
              DATA_WIDTH_ID: begin
                pending_q.data_width <= rx_opt;
                tx_req_q             <= 1'b1;
                state_q              <= CFG_ECHO;
              end
              PARITY_MODE_ID: begin
                pending_q.parity_mode <= rx_opt;
                tx_req_q              <= 1'b1;
                state_q               <= CFG_ECHO;
              end
              STOP_BITS_ID: begin
                if (stop_bits_legal(rx_opt)) begin
                  pending_q.stop_bits <= rx_opt;
                  tx_req_q            <= 1'b1;
                  state_q             <= CFG_ECHO;
                end else begin
                  fail_q <= 1'b1;
                end
              end
              default: begin
                tx_req_q <= 1'b1;
                state_q  <= CFG_ECHO;
              end
            endcase
          end else if (timer_q == TIMEOUT_LAST) begin
            timer_q   <= '0;
            fail_q    <= 1'b1;
            pending_q <= config_q;
            active_q  <= 1'b0;
            state_q   <= MAIN;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        CFG_ECHO: begin
          // A byte arriving while the echo is outstanding cannot be buffered.
          if (rx_valid_i) begin
            fail_q <= 1'b1;
          end
          if (tx_ack_i) begin
            tx_req_q <= 1'b0;
            if (end_pending_q) begin
              config_q <= pending_q;
              done_q   <= 1'b1;
              active_q <= 1'b0;
              state_q  <= MAIN;
            end else begin
              state_q <= CFG_IDLE;
            end
          end
        end
        default: begin
          tx_req_q <= 1'b0;
          active_q <= 1'b0;
          state_q  <= MAIN;
        end
      endcase
    end
  end

  assign data_o            = data_q;
  assign data_valid_o      = data_valid_q;
  assign tx_data_o         = tx_data_q;
  assign tx_req_o          = tx_req_q;
  assign config_o          = config_q;
  assign config_active_o   = active_q;
  assign int_config_req_o  = req_q;
  assign int_config_done_o = done_q;
  assign int_config_fail_o = fail_q;

endmodule

// File: tb/tb_uart_config_controller.sv
// Self-checking bench for uart_config_controller: directed table, corner
// sequences and randomized sessions against a transaction-level model.
module tb_uart_config_controller;

  localparam int SYN_N = 3;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_req_o;
  logic       tx_ack_i;
  logic [5:0] config_o;
  logic       config_active_o;
  logic       int_config_req_o;
  logic       int_config_done_o;
  logic       int_config_fail_o;

  uart_config_controller #(.SYN_NUMBER(SYN_N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .data_o(data_o), .data_valid_o(data_valid_o), .tx_data_o(tx_data_o),
    .tx_req_o(tx_req_o), .tx_ack_i(tx_ack_i), .config_o(config_o),
    .config_active_o(config_active_o), .int_config_req_o(int_config_req_o),
    .int_config_done_o(int_config_done_o), .int_config_fail_o(int_config_fail_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observed traffic, sampled just after each rising edge.
  logic [7:0] mon_fwd[$];
  int mon_req = 0, mon_done = 0, mon_fail = 0, wide_cnt = 0;
  logic prev_req = 1'b0, prev_done = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (!rst_i) begin
      if (data_valid_o) mon_fwd.push_back(data_o);
      if (int_config_req_o) mon_req++;
      if (int_config_done_o) mon_done++;
      if (int_config_fail_o) mon_fail++;
      if ((int_config_req_o && prev_req) || (int_config_done_o && prev_done)) wide_cnt++;
    end
    prev_req  = int_config_req_o;
    prev_done = int_config_done_o;
  end

  // Reference model: live/pending config, mode, SYN run, expected traffic.
  logic [5:0] m_cfg, m_pend;
  bit         m_cfg_mode;
  int         m_run;
  logic [7:0] exp_fwd[$];
  int exp_req = 0, exp_done = 0, exp_fail = 0;

  task automatic model_reset();
    m_cfg = 6'b11_00_00;
    m_pend = 6'b11_00_00;
    m_cfg_mode = 1'b0;
    m_run = 0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
  endtask

  // drop_mode: 0 none, 1 stray byte before ack, 2 stray byte with ack.
  task automatic do_ack(input logic [7:0] exp_b, input int drop_mode);
    int n = 0;
    while (!tx_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx_req_wait", tx_req_o, 1);
    check("tx_data", tx_data_o, exp_b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    if (drop_mode == 1) begin
      pulse_rx(8'($urandom));
      exp_fail++;
    end
    check("tx_data_hold", tx_data_o, exp_b);
    check("tx_req_hold", tx_req_o, 1);
    tx_ack_i = 1'b1;
    if (drop_mode == 2) begin
      rx_data_i  = 8'($urandom);
      rx_valid_i = 1'b1;
      exp_fail++;
    end
    @(negedge clk);
    tx_ack_i   = 1'b0;
    rx_valid_i = 1'b0;
    check("tx_req_drop", tx_req_o, 0);
  endtask

  task automatic main_byte(input logic [7:0] b, input int drop_mode);
    exp_fwd.push_back(b);
    m_run = (b == 8'h16) ? m_run + 1 : 0;
    pulse_rx(b);
    if (m_run == SYN_N) begin
      m_run = 0;
      m_pend = m_cfg;
      m_cfg_mode = 1'b1;
      exp_req++;
      check("cfg_entered", config_active_o, 1);
      do_ack(8'h16, drop_mode);
    end else begin
      check("stay_main", config_active_o, 0);
    end
  endtask

  task automatic cfg_byte(input logic [7:0] b, input int drop_mode, output bit saw_echo);
    logic [1:0] id, opt;
    bit e_echo, e_end;
    id = b[1:0];
    opt = b[3:2];
    e_echo = 1'b1;
    e_end = 1'b0;
    case (id)
      2'd0: e_end = 1'b1;
      2'd1: m_pend[5:4] = opt;
      2'd2: m_pend[3:2] = opt;
      default: begin
        if (opt < 2'd2) m_pend[1:0] = opt;
        else begin
          e_echo = 1'b0;
          exp_fail++;
        end
      end
    endcase
    pulse_rx(b);
    saw_echo = tx_req_o;
    check("echo_req", tx_req_o, e_echo);
    if (e_echo) begin
      do_ack(b, drop_mode);
      if (e_end) begin
        m_cfg = m_pend;
        m_cfg_mode = 1'b0;
        exp_done++;
      end
    end else begin
      @(negedge clk);
      check("no_echo", tx_req_o, 0);
    end
    check("cfg_out", config_o, m_cfg);
    check("cfg_active", config_active_o, m_cfg_mode);
  endtask

  task automatic wait_timeout();
    int n = 0;
    while (config_active_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", (n >= TO - 1 && n <= TO + 1), 1);
    exp_fail++;
    m_cfg_mode = 1'b0;
    m_pend = m_cfg;
    check("timeout_cfg", config_o, m_cfg);
  endtask

  task automatic check_counts();
    int n;
    check("req_count", mon_req, exp_req);
    check("done_count", mon_done, exp_done);
    check("fail_count", mon_fail, exp_fail);
    check("fwd_count", mon_fwd.size(), exp_fwd.size());
    n = (mon_fwd.size() < exp_fwd.size()) ? mon_fwd.size() : exp_fwd.size();
    for (int i = 0; i < n; i++) check("fwd_byte", mon_fwd[i], exp_fwd[i]);
    mon_fwd.delete();
    exp_fwd.delete();
  endtask

  typedef struct {
    bit         syn_first;
    logic [7:0] rx;
    bit         echo;
    logic [5:0] cfg;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit saw;
    logic [7:0] b;
    int nb;

    tbl[0] = '{1'b1, 8'h09, 1'b1, 6'b11_00_00};
    tbl[1] = '{1'b0, 8'h06, 1'b1, 6'b11_00_00};
    tbl[2] = '{1'b0, 8'h07, 1'b1, 6'b11_00_00};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 6'b10_01_01};
    tbl[4] = '{1'b1, 8'h0B, 1'b0, 6'b10_01_01};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 6'b10_01_01};

    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    tx_ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_config", config_o, 6'b11_00_00);
    check("rst_tx_req", tx_req_o, 0);
    check("rst_data_valid", data_valid_o, 0);
    check("rst_active", config_active_o, 0);
    check("rst_ints", {int_config_req_o, int_config_done_o, int_config_fail_o}, 3'b000);
    rst_i = 1'b0;
    @(negedge clk);

    // Directed table: full configuration, then an illegal stop-bits packet.
    foreach (tbl[i]) begin
      if (tbl[i].syn_first) repeat (3) main_byte(8'h16, 0);
      cfg_byte(tbl[i].rx, 0, saw);
      check("tbl_echo", saw, tbl[i].echo);
      check("tbl_cfg", config_o, tbl[i].cfg);
    end
    check_counts();
    check("tbl_req_total", mon_req, 2);
    check("tbl_done_total", mon_done, 2);

    // Broken SYN run followed by a completing run.
    main_byte(8'h16, 0);
    main_byte(8'h16, 0);
    main_byte(8'h41, 0);
    main_byte(8'h16, 0);
    check_counts();
    main_byte(8'h16, 0);
    main_byte(8'h16, 0);
    check("broken_run_entered", config_active_o, 1);
    cfg_byte(8'h00, 0, saw);
    check_counts();

    // Dropped bytes during ACK and echo, then reset in CFG_IDLE.
    repeat (3) main_byte(8'h16, 1);
    cfg_byte(8'h05, 1, saw);
    cfg_byte(8'h0E, 2, saw);
    check_counts();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    model_reset();
    check("midrst_config", config_o, 6'b11_00_00);
    check("midrst_tx_req", tx_req_o, 0);
    check("midrst_active", config_active_o, 0);

    // Timeout after a pending data-width write.
    repeat (3) main_byte(8'h16, 0);
    cfg_byte(8'h05, 0, saw);
    wait_timeout();
    check("timeout_not_6bit", (config_o[5:4] != 2'b01), 1);
    check_counts();

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      nb = 0;
      while (!m_cfg_mode && nb < 30) begin
        b = ($urandom_range(0, 2) != 0) ? 8'h16 : 8'($urandom);
        main_byte(b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        nb++;
      end
      if (m_cfg_mode) begin
        repeat ($urandom_range(0, 5)) begin
          b = {4'($urandom), 2'($urandom), 2'($urandom_range(1, 3))};
          cfg_byte(b, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0, saw);
        end
        if ($urandom_range(0, 5) == 0) wait_timeout();
        else cfg_byte({6'($urandom), 2'b00}, 0, saw);
      end
      check_counts();
    end

    check("pulse_width", wide_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_config_controller.md
Name: uart_config_controller

Overview:
Sequences the UART runtime configuration protocol. In normal operation it forwards received bytes to the RX buffer path and counts consecutive SYN (8'h16) characters. After SYN_NUMBER consecutive SYNs it enters configuration mode, acknowledges the host, then parses configuration packets (id in [1:0], option in [3:2], [7:4] ignored). It drives the live uart_config_s value to the TX/RX datapaths and raises the configuration interrupts. It sits between the receiver/transmitter cores and the FIFOs/interrupt logic.

Parameters:
SYN_NUMBER, 3, consecutive SYN bytes that start a configuration request (range 1..7).
TIMEOUT_CYCLES, 1_000_000, idle clock cycles in configuration mode before abort (10 ms at 100 MHz); counter width is clog2(TIMEOUT_CYCLES+1).

Ports:
clk_i  in  1  system clock; all logic is on the rising edge.
rst_i  in  1  synchronous reset, active-high.
rx_data_i  in  8  byte from the receiver core.
rx_valid_i  in  1  single-cycle pulse; rx_data_i is valid.
data_o  out  8  forwarded byte to the RX FIFO.
data_valid_o  out  1  single-cycle write strobe to the RX FIFO.
tx_data_o  out  8  byte the controller transmits (ACK/echo).
tx_req_o  out  1  transmit request; held high until tx_ack_i.
tx_ack_i  in  1  transmitter accepted tx_data_o.
config_o  out  6  live uart_config_s {data_width, parity_mode, stop_bits}.
config_active_o  out  1  high while not in MAIN.
int_config_req_o  out  1  pulse on entry to configuration mode.
int_config_done_o  out  1  pulse when the new configuration is applied.
int_config_fail_o  out  1  pulse on an illegal packet, dropped byte or timeout.

Behaviour:
- Reset values: config_o = STD_CONFIGURATION = 6'b11_00_00 (8-bit, even, 1 stop). Pending config register = same value. State = MAIN. SYN counter = 0. Timeout counter = 0. All other outputs = 0.
- States: MAIN, CFG_ACK, CFG_IDLE, CFG_ECHO.
- MAIN:
  - Every rx_valid_i byte, SYN included, is forwarded: data_o = rx_data_i, with data_valid_o high on the next cycle (1-cycle latency, registered).
  - A SYN byte increments the counter. A non-SYN byte clears it.
  - When a SYN brings the count to SYN_NUMBER:
    - clear the counter;
    - copy config_o into the pending register;
    - pulse int_config_req_o;
    - go to CFG_ACK.
- CFG_ACK:
  - tx_data_o = SYN, tx_req_o = 1.
  - On tx_ack_i, drop tx_req_o the next cycle and go to CFG_IDLE.
  - tx_data_o is stable while tx_req_o is high.
- CFG_IDLE:
  - No bytes are forwarded (data_valid_o = 0).
  - The timeout counter increments each cycle without rx_valid_i. Any rx_valid_i clears it.
  - On reaching TIMEOUT_CYCLES:
    - pulse int_config_fail_o;
    - discard the pending register (config_o unchanged);
    - go to MAIN.
  - Decode of a received byte by id:
    - DATA_WIDTH_ID (01): pending.data_width = option. Echo.
    - PARITY_MODE_ID (10): pending.parity_mode = option. All four codes are legal. Echo.
    - STOP_BITS_ID (11): option 00/01 are written and echoed. Option 10/11 are illegal: pending is unchanged, int_config_fail_o pulses, no echo, state stays CFG_IDLE.
    - END_CONFIGURATION_ID (00): echo, then apply.
  - Echo means: tx_data_o = received byte unmodified, go to CFG_ECHO.
- CFG_ECHO:
  - tx_req_o = 1 until tx_ack_i.
  - For a non-END byte, return to CFG_IDLE.
  - For END, on the tx_ack_i cycle: load config_o from pending (visible the next cycle), pulse int_config_done_o, go to MAIN.
  - An rx_valid_i received in CFG_ECHO or CFG_ACK is dropped and pulses int_config_fail_o. The state is not changed.
- Timeout counting is suspended in CFG_ACK and CFG_ECHO.
- rx_valid_i together with tx_ack_i in CFG_ECHO: the byte is dropped (fail pulse) and the transition still occurs.
- config_o changes only on an END completion or on reset. It never changes mid-configuration.
- Reset mid-operation: immediately returns to the reset values. A pending tx_req_o is dropped and pending updates are lost.
- Interrupt pulses are exactly 1 cycle wide.

Test Plan:
- Reset check: assert rst_i for 2 cycles -> config_o = 6'b110000; tx_req_o, data_valid_o, all interrupts and config_active_o = 0.
- Full configuration: send 16,16,16 (int_config_req_o pulse, ACK 8'h16 sent), then 8'h09, 8'h06, 8'h07, 8'h00, acking each echo -> echoes match the inputs byte for byte; config_o = 6'b10_01_01 one cycle after the final tx_ack_i; int_config_done_o pulses once.
- Broken SYN run: send 16,16,41,16 -> all four bytes forwarded on data_o, no state change; a further 16,16 completes 3 consecutive SYNs -> configuration entered.
- Illegal packet: in configuration, send 8'h0B (stop bits reserved) -> int_config_fail_o pulse, no tx_req_o, then 8'h00 -> config_o keeps its previous value.
- Timeout: with TIMEOUT_CYCLES=100, enter configuration, send 8'h05, ack its echo, then stay idle 100 cycles -> fail pulse, state MAIN, config_o unchanged (data width not 6-bit).
- Dropped byte and reset: send an rx byte while tx_req_o is waiting for its echo ack -> dropped with a fail pulse; then assert rst_i during CFG_IDLE -> config_o = 6'b110000 and tx_req_o = 0 next cycle.
